// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline stage with handshaked data-memory access
//
// Purpose:
//   Passes non-memory instructions straight to the WB registers with one cycle
//   of latency. Loads and stores are captured and issued to data memory via a
//   req/ack handshake, stalling upstream until the access completes or a
//   timeout expires (in which case the instruction is squashed and DM_ERR
//   latches high until reset).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   MEM_VALID .. MEM_RD_SEL    MEM-stage instruction fields (held while MEM_STALL)
//   DM_REQ/DM_WE/DM_ADDR/
//   DM_WDATA                   data-memory request side (DM_REQ high only in WAIT)
//   DM_RDATA/DM_ACK            data-memory response side
//   MEM_STALL                  combinational stall to upstream
//   DM_ERR                     sticky access-timeout flag
//   WB_VALID/WB_RF_WE/
//   WB_RF_DATA/WB_RD_SEL       writeback-stage registers

module mem_wb_stage #(
  parameter logic [7:0] DM_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_VALID,
  input  logic        MEM_DM_WE,
  input  logic [31:0] MEM_ALU_RES,
  input  logic [31:0] MEM_muxB,
  input  logic [15:0] MEM_DM_ADDR,
  input  logic [1:0]  MEM_RF_D_SEL,
  input  logic [31:0] MEM_NEXT_PC,
  input  logic [1:0]  MEM_RD_SEL,
  output logic        DM_REQ,
  output logic        DM_WE,
  output logic [15:0] DM_ADDR,
  output logic [31:0] DM_WDATA,
  input  logic [31:0] DM_RDATA,
  input  logic        DM_ACK,
  output logic        MEM_STALL,
  output logic        DM_ERR,
  output logic        WB_VALID,
  output logic        WB_RF_WE,
  output logic [31:0] WB_RF_DATA,
  output logic [1:0]  WB_RD_SEL
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;

  // Captured copies of the fields needed once the access completes.
  logic [31:0] cap_alu;
  logic [1:0]  cap_rf_d_sel;
  logic [1:0]  cap_rd_sel;

  logic        memop;
  logic        timeout;
  logic        capture;   // IDLE -> WAIT: latch request fields
  logic        wb_pass;   // IDLE, no memop: WB loads directly from inputs
  logic        wb_mem;    // WAIT with ACK: WB loads the completed access
  logic        wb_clear;  // bubble into WB (capture, waiting, or squash)
  logic        err_set;

  assign memop   = MEM_VALID && (MEM_DM_WE || (MEM_RF_D_SEL == 2'd1));
  assign timeout = (cnt == DM_TIMEOUT);

  // DM_REQ is decoded from the state register so that an asynchronous reset
  // drops it immediately, without waiting for a clock edge.
  assign DM_REQ = (state == S_WAIT);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    MEM_STALL = 1'b0;
    capture   = 1'b0;
    wb_pass   = 1'b0;
    wb_mem    = 1'b0;
    wb_clear  = 1'b0;
    err_set   = 1'b0;
    case (state)
      S_IDLE: begin
        // DM_ACK is deliberately not looked at here.
        if (memop) begin
          MEM_STALL = 1'b1;
          capture   = 1'b1;
          cnt_nxt   = 8'd0;
          wb_clear  = 1'b1;
          state_nxt = S_WAIT;
        end else begin
          wb_pass = 1'b1;
        end
      end
      S_WAIT: begin
        if (DM_ACK) begin
          // ACK wins over a coincident timeout.
          wb_mem    = 1'b1;
          state_nxt = S_IDLE;
        end else if (timeout) begin
          // Release upstream this cycle; the instruction is dropped.
          wb_clear  = 1'b1;
          err_set   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          MEM_STALL = 1'b1;
          wb_clear  = 1'b1;
          cnt_nxt   = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DM_WE        <= 1'b0;
      DM_ADDR      <= 16'd0;
      DM_WDATA     <= 32'd0;
      cap_alu      <= 32'd0;
      cap_rf_d_sel <= 2'd0;
      cap_rd_sel   <= 2'd0;
    end else if (capture) begin
      DM_WE        <= MEM_DM_WE;
      DM_ADDR      <= MEM_DM_ADDR;
      DM_WDATA     <= MEM_muxB;
      cap_alu      <= MEM_ALU_RES;
      cap_rf_d_sel <= MEM_RF_D_SEL;
      cap_rd_sel   <= MEM_RD_SEL;
    end
  end

  // Sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DM_ERR <= 1'b0;
    end else if (err_set) begin
      DM_ERR <= 1'b1;
    end
  end

  // Writeback registers. Data and destination hold their last value while
  // a bubble is inserted; only the valid/write-enable bits are cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB_VALID   <= 1'b0;
      WB_RF_WE   <= 1'b0;
      WB_RF_DATA <= 32'd0;
      WB_RD_SEL  <= 2'd0;
    end else if (wb_pass) begin
      WB_VALID   <= MEM_VALID;
      WB_RF_WE   <= MEM_VALID;
      WB_RF_DATA <= (MEM_RF_D_SEL == 2'd2) ? MEM_NEXT_PC : MEM_ALU_RES;
      WB_RD_SEL  <= MEM_RD_SEL;
    end else if (wb_mem) begin
      WB_VALID   <= 1'b1;
      WB_RF_WE   <= !DM_WE;
      WB_RF_DATA <= (!DM_WE && (cap_rf_d_sel == 2'd1)) ? DM_RDATA : cap_alu;
      WB_RD_SEL  <= cap_rd_sel;
    end else if (wb_clear) begin
      WB_VALID   <= 1'b0;
      WB_RF_WE   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage

module tb_mem_wb_stage;

  localparam logic [7:0] TO = 8'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MEM_VALID, MEM_DM_WE;
  logic [31:0] MEM_ALU_RES, MEM_muxB, MEM_NEXT_PC;
  logic [15:0] MEM_DM_ADDR;
  logic [1:0]  MEM_RF_D_SEL, MEM_RD_SEL;
  logic        DM_REQ, DM_WE;
  logic [15:0] DM_ADDR;
  logic [31:0] DM_WDATA, DM_RDATA;
  logic        DM_ACK;
  logic        MEM_STALL, DM_ERR;
  logic        WB_VALID, WB_RF_WE;
  logic [31:0] WB_RF_DATA;
  logic [1:0]  WB_RD_SEL;

  mem_wb_stage #(.DM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .MEM_VALID(MEM_VALID), .MEM_DM_WE(MEM_DM_WE), .MEM_ALU_RES(MEM_ALU_RES),
    .MEM_muxB(MEM_muxB), .MEM_DM_ADDR(MEM_DM_ADDR), .MEM_RF_D_SEL(MEM_RF_D_SEL),
    .MEM_NEXT_PC(MEM_NEXT_PC), .MEM_RD_SEL(MEM_RD_SEL),
    .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
    .DM_RDATA(DM_RDATA), .DM_ACK(DM_ACK),
    .MEM_STALL(MEM_STALL), .DM_ERR(DM_ERR),
    .WB_VALID(WB_VALID), .WB_RF_WE(WB_RF_WE), .WB_RF_DATA(WB_RF_DATA),
    .WB_RD_SEL(WB_RD_SEL)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rf_we;
    logic [31:0] data;
    logic [1:0]  rd;
  } wb_t;

  wb_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_err = 1'b0;

  // Scoreboard monitor: every WB_VALID pulse must match the oldest expectation,
  // and every queued expectation must show up on the edge it was pushed for.
  always @(posedge clk) begin
    wb_t e;
    #2;
    if (WB_VALID === 1'b1 || exp_q.size() > 0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: WB_VALID=%b data=%h with nothing expected", WB_VALID, WB_RF_DATA);
      end else begin
        e = exp_q.pop_front();
        if (WB_VALID !== 1'b1 || WB_RF_WE !== e.rf_we || WB_RF_DATA !== e.data || WB_RD_SEL !== e.rd) begin
          errors++;
          $display("FAIL wb_result: got valid=%b we=%b data=%h rd=%0d, expected valid=1 we=%b data=%h rd=%0d",
                   WB_VALID, WB_RF_WE, WB_RF_DATA, WB_RD_SEL, e.rf_we, e.data, e.rd);
        end
      end
    end
  end

  // Issue one instruction and play the memory side. ack_at is the WAIT cycle
  // index carrying DM_ACK (-1 = never). Returns 1 ns after the edge that
  // leaves WAIT (or the WB edge for non-memops), ready for back-to-back issue.
  task automatic do_op(input logic v, input logic we, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] npc, input logic [15:0] addr,
                       input logic [1:0] rd, input int ack_at,
                       input logic [31:0] rdata, input logic idle_ack);
    logic memop;
    logic ack;
    logic done;
    int   req_cyc;
    int   exp_cyc;
    wb_t  e;
    @(negedge clk);
    MEM_VALID = v; MEM_DM_WE = we; MEM_RF_D_SEL = sel; MEM_ALU_RES = alu;
    MEM_muxB = wd; MEM_NEXT_PC = npc; MEM_DM_ADDR = addr; MEM_RD_SEL = rd;
    DM_ACK = idle_ack; DM_RDATA = 32'h0BAD0BAD;
    memop = v && (we || sel == 2'd1);
    #1;
    checks++;
    if (MEM_STALL !== memop) begin
      errors++;
      $display("FAIL stall_idle: MEM_STALL=%b expected %b", MEM_STALL, memop);
    end
    if (!memop) begin
      if (v) begin
        e.rf_we = 1'b1; e.data = (sel == 2'd2) ? npc : alu; e.rd = rd;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
    end else begin
      @(negedge clk);
      checks++;
      if (DM_REQ !== 1'b1 || DM_ADDR !== addr || DM_WE !== we || DM_WDATA !== wd) begin
        errors++;
        $display("FAIL dm_request: req=%b addr=%h we=%b wdata=%h expected 1 %h %b %h",
                 DM_REQ, DM_ADDR, DM_WE, DM_WDATA, addr, we, wd);
      end
      req_cyc = 0;
      done = 1'b0;
      for (int k = 0; k <= int'(TO) && !done; k++) begin
        if (k > 0) @(negedge clk);
        ack = (k == ack_at);
        DM_ACK = ack;
        DM_RDATA = ack ? rdata : 32'hDEADBEEF;
        #1;
        if (DM_REQ === 1'b1) req_cyc++;
        checks++;
        if (MEM_STALL !== !(ack || k == int'(TO))) begin
          errors++;
          $display("FAIL stall_wait: cycle %0d MEM_STALL=%b expected %b", k, MEM_STALL, !(ack || k == int'(TO)));
        end
        if (ack) begin
          e.rf_we = !we; e.data = we ? alu : rdata; e.rd = rd;
          exp_q.push_back(e);
          done = 1'b1;
        end else if (k == int'(TO)) begin
          exp_err = 1'b1;
          done = 1'b1;
        end
      end
      exp_cyc = (ack_at >= 0 && ack_at <= int'(TO)) ? ack_at + 1 : int'(TO) + 1;
      checks++;
      if (req_cyc != exp_cyc) begin
        errors++;
        $display("FAIL req_cycles: DM_REQ high %0d cycles expected %0d", req_cyc, exp_cyc);
      end
      @(posedge clk);
      #1;
      checks++;
      if (DM_REQ !== 1'b0 || DM_ERR !== exp_err) begin
        errors++;
        $display("FAIL after_access: DM_REQ=%b DM_ERR=%b expected 0 %b", DM_REQ, DM_ERR, exp_err);
      end
    end
  endtask

  task automatic go_idle(input int n);
    @(negedge clk);
    MEM_VALID = 1'b0; MEM_DM_WE = 1'b0; DM_ACK = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (DM_REQ !== 1'b0 || DM_WE !== 1'b0 || DM_ADDR !== 16'd0 || DM_WDATA !== 32'd0 ||
        DM_ERR !== 1'b0 || WB_VALID !== 1'b0 || WB_RF_WE !== 1'b0 ||
        WB_RF_DATA !== 32'd0 || WB_RD_SEL !== 2'd0) begin
      errors++;
      $display("FAIL %s: req=%b we=%b addr=%h wd=%h err=%b wbv=%b wbwe=%b wbd=%h rd=%0d expected all 0",
               name, DM_REQ, DM_WE, DM_ADDR, DM_WDATA, DM_ERR, WB_VALID, WB_RF_WE, WB_RF_DATA, WB_RD_SEL);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    MEM_VALID = 1'b0; MEM_DM_WE = 1'b0; MEM_ALU_RES = '0; MEM_muxB = '0;
    MEM_NEXT_PC = '0; MEM_DM_ADDR = '0; MEM_RF_D_SEL = '0; MEM_RD_SEL = '0;
    DM_ACK = 1'b0; DM_RDATA = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    do_op(1, 0, 2'd0, 32'h12345678, 32'h0, 32'h0, 16'h0, 2'd2, -1, 32'h0, 1'b1);
    do_op(1, 0, 2'd3, 32'h0F0F1111, 32'h0, 32'h00000400, 16'h0, 2'd1, -1, 32'h0, 1'b0);
    do_op(1, 0, 2'd2, 32'h55555555, 32'h0, 32'h00001004, 16'h0, 2'd3, -1, 32'h0, 1'b0);
    do_op(0, 0, 2'd0, 32'h77777777, 32'h0, 32'h0, 16'h0, 2'd1, -1, 32'h0, 1'b1);
    do_op(0, 1, 2'd1, 32'h88888888, 32'h0, 32'h0, 16'h0, 2'd1, -1, 32'h0, 1'b0);
    go_idle(1);
  endtask

  task automatic test_load();
    do_op(1, 0, 2'd1, 32'h00000040, 32'h0, 32'h0, 16'h0040, 2'd1, 2, 32'hCAFEF00D, 1'b1);
    go_idle(1);
  endtask

  task automatic test_store();
    do_op(1, 1, 2'd0, 32'h00000010, 32'hA5A5A5A5, 32'h0, 16'h0010, 2'd2, 0, 32'h0, 1'b0);
    go_idle(1);
  endtask

  task automatic test_ack_on_timeout();
    do_op(1, 0, 2'd1, 32'h00000099, 32'h0, 32'h0, 16'h0099, 2'd3, int'(TO), 32'h13579BDF, 1'b0);
    go_idle(1);
  endtask

  task automatic test_timeout();
    do_op(1, 0, 2'd1, 32'h00000200, 32'h0, 32'h0, 16'h0200, 2'd1, -1, 32'h0, 1'b0);
    do_op(1, 0, 2'd0, 32'hFEEDFACE, 32'h0, 32'h0, 16'h0, 2'd2, -1, 32'h0, 1'b0);
    go_idle(1);
    checks++;
    if (DM_ERR !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: DM_ERR=%b expected 1", DM_ERR);
    end
  endtask

  task automatic test_back_to_back();
    do_op(1, 0, 2'd1, 32'h0, 32'h0, 32'h0, 16'h0100, 2'd1, 1, 32'h11112222, 1'b0);
    do_op(1, 0, 2'd1, 32'h0, 32'h0, 32'h0, 16'h0104, 2'd2, 0, 32'h33334444, 1'b0);
    do_op(1, 1, 2'd0, 32'hAAAA0000, 32'h5A5A5A5A, 32'h0, 16'h0108, 2'd3, 3, 32'h0, 1'b0);
    do_op(1, 0, 2'd0, 32'h0000BEEF, 32'h0, 32'h0, 16'h0, 2'd0, -1, 32'h0, 1'b0);
    go_idle(1);
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    MEM_VALID = 1'b1; MEM_DM_WE = 1'b0; MEM_RF_D_SEL = 2'd1;
    MEM_DM_ADDR = 16'h0300; MEM_RD_SEL = 2'd2; DM_ACK = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (DM_REQ !== 1'b1) begin
      errors++;
      $display("FAIL mid_wait_req: DM_REQ=%b expected 1", DM_REQ);
    end
    MEM_VALID = 1'b0;
    #1;
    rst_n = 1'b0;
    exp_err = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1, 0, 2'd1, 32'h0, 32'h0, 32'h0, 16'h0044, 2'd3, 1, 32'h600DF00D, 1'b0);
    go_idle(2);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_ack_on_timeout();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results never appeared, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
